// File: rtl/ir_assembler.sv
// rtl/ir_assembler.sv - collects BEATS bus beats into one instruction word with hold/take handshake
// Build option IR_LSB_FIRST_EN: first beat lands in the least significant slot instead of the most.
module ir_assembler #(
    parameter int DATA_W = 8,
    parameter int BEATS  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [DATA_W-1:0]            data,
    input  logic                         flush,
    input  logic                         ir_take,
    output logic                         in_ready,
    output logic [DATA_W*BEATS-1:0]      opc_iraddr,
    output logic                         ir_valid,
    output logic [$clog2(BEATS)-1:0]     beat_cnt,
    output logic                         abort,
    output logic                         ovf
);

    localparam int W  = DATA_W * BEATS;
    localparam int CW = $clog2(BEATS);
`ifdef IR_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    if (BEATS < 2 || BEATS > 8) begin : g_bad_beats
        $error("ir_assembler: BEATS must be in 2..8");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
        $error("ir_assembler: DATA_W must be in 1..32");
    end

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shadow_q;
    logic [W-1:0]    word_next;
    logic [CW-1:0]   cnt_q;
    logic            last_beat;

    assign last_beat = (cnt_q == CW'(BEATS - 1));
    assign beat_cnt  = cnt_q;

    // Shadow with the incoming beat dropped into the slot selected by the running count.
    always_comb begin
        word_next = shadow_q;
        for (int n = 0; n < BEATS; n++) begin
            if (cnt_q == CW'(n)) begin
                if (LSB_FIRST)
                    word_next[n*DATA_W +: DATA_W] = data;
                else
                    word_next[W-(n+1)*DATA_W +: DATA_W] = data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (ena) state_d = FILL;
                FILL: begin
                    if (!ena)           state_d = IDLE;
                    else if (last_beat) state_d = FULL;
                end
                FULL: begin
                    if (ir_take) state_d = ena ? FILL : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q != FULL) || ir_take;
        ir_valid = (state_q == FULL);
    end

    // The shadow and count are always zero in IDLE and FULL, so a new word starts from a clean slate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            cnt_q      <= '0;
            opc_iraddr <= '0;
            abort      <= 1'b0;
            ovf        <= 1'b0;
        end else if (flush) begin
            shadow_q   <= '0;
            cnt_q      <= '0;
            opc_iraddr <= '0;
            abort      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            abort <= (state_q == FILL) && !ena;
            if ((state_q == FULL) && ena && !ir_take)
                ovf <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (ena) begin
                        shadow_q <= word_next;
                        cnt_q    <= CW'(1);
                    end
                end
                FILL: begin
                    if (!ena) begin
                        shadow_q <= '0;
                        cnt_q    <= '0;
                    end else if (last_beat) begin
                        opc_iraddr <= word_next;
                        shadow_q   <= '0;
                        cnt_q      <= '0;
                    end else begin
                        shadow_q <= word_next;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                end
                FULL: begin
                    if (ir_take && ena) begin
                        shadow_q <= word_next;
                        cnt_q    <= CW'(1);
                    end
                end
                default: begin
                    shadow_q <= '0;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_assembler.sv
// tb/tb_ir_assembler.sv - vector table, hand sequences and random run against a queue model
module tb_ir_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        ena = 1'b0, flush = 1'b0, ir_take = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        in_ready, ir_valid, abort, ovf;
    logic [15:0] opc;
    logic [0:0]  cnt;

    logic        ena4 = 1'b0, flush4 = 1'b0, take4 = 1'b0;
    logic [7:0]  data4 = 8'h00;
    logic        ready4, valid4, abort4, ovf4;
    logic [31:0] opc4;
    logic [1:0]  cnt4;

    ir_assembler #(.DATA_W(8), .BEATS(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data(data), .flush(flush), .ir_take(ir_take),
        .in_ready(in_ready), .opc_iraddr(opc), .ir_valid(ir_valid), .beat_cnt(cnt),
        .abort(abort), .ovf(ovf)
    );

    ir_assembler #(.DATA_W(8), .BEATS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .data(data4), .flush(flush4), .ir_take(take4),
        .in_ready(ready4), .opc_iraddr(opc4), .ir_valid(valid4), .beat_cnt(cnt4),
        .abort(abort4), .ovf(ovf4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word built from an ordered list of beats, following the placement rule of the build.
    function automatic logic [31:0] pack(input logic [7:0] b[$]);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < b.size(); i++) begin
`ifdef IR_LSB_FIRST_EN
            w = w | ({24'd0, b[i]} << (8 * i));
`else
            w = (w << 8) | {24'd0, b[i]};
`endif
        end
        return w;
    endfunction

    function automatic logic [31:0] fix16(input logic [15:0] msb_first);
        logic [7:0] q[$];
        q = {msb_first[15:8], msb_first[7:0]};
        return pack(q);
    endfunction

    typedef struct {
        logic        ena;
        logic [7:0]  data;
        logic        flush;
        logic        take;
        logic        exp_ready;
        logic        exp_valid;
        logic [15:0] exp_opc;
        logic        exp_cnt;
        logic        exp_abort;
        logic        exp_ovf;
    } vec_t;

    vec_t tv[14];

    logic [7:0]  mq[$];
    logic        mvalid, movf, mabort;
    logic [31:0] mopc;
    logic [7:0]  bq[$];

    initial begin
        tv[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA53C, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA53C, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA53C, 1'b0, 1'b0, 1'b1};
        tv[4]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA53C, 1'b1, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA53C, 1'b0, 1'b1, 1'b1};
        tv[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA53C, 1'b0, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA53C, 1'b0, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA53C, 1'b1, 1'b0, 1'b1};
        tv[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA53C, 1'b0, 1'b1, 1'b1};
        tv[10] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 16'hA53C, 1'b1, 1'b0, 1'b1};
        tv[11] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2233, 1'b0, 1'b0, 1'b1};
        tv[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1};
        tv[13] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

        // Reset state
        step();
        step();
        check("rst_opc", 0, 32'(opc), 32'd0);
        check("rst_valid", 0, 32'(ir_valid), 32'd0);
        check("rst_cnt", 0, 32'(cnt), 32'd0);
        check("rst_abort", 0, 32'(abort), 32'd0);
        check("rst_ovf", 0, 32'(ovf), 32'd0);
        check("rst_ready", 0, 32'(in_ready), 32'd1);
        #2 rst_n = 1'b1;

        // Four-beat word: output holds its prior word until the last beat lands
        bq = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) begin
            ena4 = 1'b1; data4 = bq[i];
            step();
        end
        ena4 = 1'b0;
        check("b4_first_valid", 0, 32'(valid4), 32'd1);
        check("b4_first_opc", 0, opc4, pack(bq));
        take4 = 1'b1;
        step();
        take4 = 1'b0;
        check("b4_take_valid", 0, 32'(valid4), 32'd0);
        bq = {8'h12, 8'h34, 8'h56, 8'h78};
        for (int i = 0; i < 4; i++) begin
            ena4 = 1'b1; data4 = bq[i];
            step();
            if (i < 3) begin
                check("b4_mid_valid", i, 32'(valid4), 32'd0);
                check("b4_mid_opc", i, opc4, pack({8'hAA, 8'hBB, 8'hCC, 8'hDD}));
                check("b4_mid_cnt", i, 32'(cnt4), 32'(i + 1));
            end
        end
        ena4 = 1'b0;
        check("b4_word_valid", 0, 32'(valid4), 32'd1);
        check("b4_word_opc", 0, opc4, pack(bq));
        check("b4_word_cnt", 0, 32'(cnt4), 32'd0);

        // Vector table on the two-beat instance
        for (int i = 0; i < 14; i++) begin
            ena = tv[i].ena; data = tv[i].data; flush = tv[i].flush; ir_take = tv[i].take;
            #1;
            check("tv_ready", i, 32'(in_ready), 32'(tv[i].exp_ready));
            step();
            check("tv_valid", i, 32'(ir_valid), 32'(tv[i].exp_valid));
            check("tv_opc", i, 32'(opc), tv[i].exp_opc == 16'h0 ? 32'd0 : fix16(tv[i].exp_opc));
            check("tv_cnt", i, 32'(cnt), 32'(tv[i].exp_cnt));
            check("tv_abort", i, 32'(abort), 32'(tv[i].exp_abort));
            check("tv_ovf", i, 32'(ovf), 32'(tv[i].exp_ovf));
        end
        flush = 1'b0; ir_take = 1'b0;

        // Held word with an overflowing beat, then take coinciding with a new beat
        ena = 1'b1; data = 8'hBE; step();
        data = 8'hEF; step();
        check("beef_opc", 0, 32'(opc), fix16(16'hBEEF));
        data = 8'h01;
        #1 check("beef_ready", 0, 32'(in_ready), 32'd0);
        step();
        check("beef_ovf", 0, 32'(ovf), 32'd1);
        check("beef_hold", 0, 32'(opc), fix16(16'hBEEF));
        data = 8'h02; ir_take = 1'b1;
        step();
        ir_take = 1'b0;
        check("beef_take_valid", 0, 32'(ir_valid), 32'd0);
        check("beef_take_cnt", 0, 32'(cnt), 32'd1);

        // Asynchronous reset in the middle of a cycle while filling
        #3 rst_n = 1'b0;
        #1;
        check("areset_cnt", 0, 32'(cnt), 32'd0);
        check("areset_ovf", 0, 32'(ovf), 32'd0);
        check("areset_opc", 0, 32'(opc), 32'd0);
        check("areset_valid", 0, 32'(ir_valid), 32'd0);
        check("areset_abort", 0, 32'(abort), 32'd0);
        ena = 1'b1; data = 8'hA5;
        #3 rst_n = 1'b1;
        step();
        check("post_reset_cnt", 0, 32'(cnt), 32'd1);
        check("post_reset_abort", 0, 32'(abort), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Randomized run against the queue model
        mq.delete(); mvalid = 1'b0; movf = 1'b0; mabort = 1'b0; mopc = 32'd0;
        for (int i = 0; i < 400; i++) begin
            ena = ($urandom_range(0, 9) < 8);
            ir_take = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 39) == 0);
            data = 8'($urandom);
            #1;
            check("rnd_ready", i, 32'(in_ready), 32'(!mvalid || ir_take));
            if (flush) begin
                mq.delete(); mvalid = 1'b0; movf = 1'b0; mabort = 1'b0; mopc = 32'd0;
            end else begin
                logic rdy;
                rdy = !mvalid || ir_take;
                mabort = (mq.size() > 0) && !ena;
                if (ena && !rdy) movf = 1'b1;
                if (mvalid && ir_take) mvalid = 1'b0;
                if (mq.size() > 0 && !ena) begin
                    mq.delete();
                end else if (ena && rdy) begin
                    mq.push_back(data);
                    if (mq.size() == 2) begin
                        mopc = pack(mq);
                        mvalid = 1'b1;
                        mq.delete();
                    end
                end
            end
            step();
            check("rnd_valid", i, 32'(ir_valid), 32'(mvalid));
            check("rnd_opc", i, 32'(opc), mopc);
            check("rnd_cnt", i, 32'(cnt), 32'(mq.size()));
            check("rnd_abort", i, 32'(abort), 32'(mabort));
            check("rnd_ovf", i, 32'(ovf), 32'(movf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ir_assembler.md
IR_ASSEMBLER -- requirements
Module: ir_assembler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bus beat width in bits (1..32).
REQ-002 SHALL have parameter BEATS, default 2, beats per instruction word (2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port ena  input  1  beat strobe; data is offered while high.
REQ-006 SHALL have port data  input  DATA_W  instruction beat.
REQ-007 SHALL have port flush  input  1  synchronous clear of all assembly state.
REQ-008 SHALL have port ir_take  input  1  consumer accepts the held word.
REQ-009 SHALL have port in_ready  output  1  beat acceptance indicator, combinational.
REQ-010 SHALL have port opc_iraddr  output  DATA_W*BEATS  assembled instruction word, registered.
REQ-011 SHALL have port ir_valid  output  1  opc_iraddr holds a complete, untaken word.
REQ-012 SHALL have port beat_cnt  output  clog2(BEATS)  beats collected in the current word.
REQ-013 SHALL have port abort  output  1  one-cycle pulse when a partial word is discarded.
REQ-014 SHALL have port ovf  output  1  sticky: beat offered while not ready.

Function
REQ-015 SHALL implement states IDLE (beat_cnt=0), FILL (0<beat_cnt<BEATS), FULL (ir_valid=1).
REQ-016 SHALL drive in_ready = (state != FULL) or ir_take.
REQ-017 SHALL accept a beat on an edge where ena and in_ready are both high.
REQ-018 SHALL place beat n (0-based) in a shadow register at bits [W-1-n*DATA_W -: DATA_W], with W = DATA_W*BEATS (first beat MSB).
REQ-019 SHALL, on acceptance of beat BEATS-1, copy the full word to opc_iraddr, set ir_valid, and zero beat_cnt on that same edge.
REQ-020 SHALL never expose a partially assembled word on opc_iraddr.
REQ-021 SHALL hold opc_iraddr and ir_valid in FULL until ir_take; ir_take clears ir_valid and leaves opc_iraddr unchanged.
REQ-022 SHALL, when ir_take and ena coincide in FULL, clear ir_valid and accept that beat as beat 0 of the next word.
REQ-023 SHALL ignore ir_take while ir_valid=0.
REQ-024 SHALL, if ena is low on any edge in FILL, discard the shadow contents, set beat_cnt=0, return to IDLE and pulse abort high for exactly one cycle.
REQ-025 SHALL, when ena is high with in_ready low, ignore the beat and set ovf, which stays set until flush or reset.
REQ-026 SHALL give flush priority over all other inputs: clear the shadow, beat_cnt, ir_valid, ovf, abort and opc_iraddr to 0, and enter IDLE.
REQ-027 SHALL support BEATS=1 as invalid; elaboration SHALL fail for BEATS<2 or BEATS>8.

Reset
REQ-028 SHALL, while rst_n=0, immediately force opc_iraddr=0, ir_valid=0, beat_cnt=0, abort=0, ovf=0, shadow=0, state IDLE.
REQ-029 SHALL discard any partially assembled or held word when reset is asserted; no abort pulse is generated.
REQ-030 SHALL accept the first beat on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with macro IR_LSB_FIRST_EN defined, place beat n at bits [n*DATA_W +: DATA_W] (first beat LSB).
REQ-032 SHALL, without IR_LSB_FIRST_EN, use MSB-first placement per REQ-018; no other behaviour differs.

Verification
REQ-033 SHALL cover the following: defaults; ena=1 with data 0xA5 then 0x3C, ir_take=0 -> after edge 2, opc_iraddr=0xA53C, ir_valid=1, beat_cnt=0; with IR_LSB_FIRST_EN -> 0x3CA5.
REQ-034 SHALL cover the following: BEATS=4; beats 0x12,0x34,0x56,0x78 -> opc_iraddr=0x12345678; ir_valid rises only after beat 4, and opc_iraddr holds its prior value through beats 1-3.
REQ-035 SHALL cover the following: defaults; beat 0x11 accepted, ena=0 next edge -> abort=1 for one cycle, beat_cnt=0; then 0x22,0x33 -> 0x2233.
REQ-036 SHALL cover the following: word 0xBEEF held, ena=1 data 0x01 with ir_take=0 -> ovf=1, opc_iraddr stays 0xBEEF; next cycle ir_take=1 with ena=1 data 0x02 -> ir_valid=0, beat_cnt=1.
REQ-037 SHALL cover the following: rst_n pulsed low mid-cycle during FILL -> outputs 0 without waiting for a clock edge; flush=1 with ena=1 -> beat ignored, all state 0.
